// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction-fetch stage: FSM encoding and default parameters.
package fetch_unit_pkg;

  localparam int unsigned TAMANHO       = 32;
  localparam int unsigned ENDERECAMENTO = 10;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEF_HALT_WORD = 32'hFFFF_FFFF;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port plus decode-side redirect/stall and results.
interface fetch_unit_if #(
  parameter int unsigned tamanho = 32
);

  logic [tamanho-1:0] Address;
  logic [tamanho-1:0] i_out;
  logic               stall;
  logic               branch_taken;
  logic [tamanho-1:0] branch_offset;
  logic               jump;
  logic [25:0]        jump_target;
  logic               jr;
  logic [tamanho-1:0] jr_addr;
  logic [tamanho-1:0] instr;
  logic [tamanho-1:0] pc_out;
  logic [tamanho-1:0] pc_plus4;
  logic               instr_valid;
  logic               halt;
  logic               fault;

  modport master (
    output Address, instr, pc_out, pc_plus4, instr_valid, halt, fault,
    input  i_out, stall, branch_taken, branch_offset, jump, jump_target, jr, jr_addr
  );

  modport slave (
    input  Address, instr, pc_out, pc_plus4, instr_valid, halt, fault,
    output i_out, stall, branch_taken, branch_offset, jump, jump_target, jr, jr_addr
  );

endinterface

// File: rtl/fetch_unit_next_pc_sel.sv
// Next-PC selection: redirect target computation, jr > jump > branch priority, fault detection.
module fetch_unit_next_pc_sel #(
  parameter int unsigned tamanho       = 32,
  parameter int unsigned enderecamento = 10
) (
  input  logic [tamanho-1:0] pc_i,
  input  logic [tamanho-1:0] pc_plus4_i,
  input  logic               redirect_en_i,
  input  logic               branch_taken_i,
  input  logic [tamanho-1:0] branch_offset_i,
  input  logic               jump_i,
  input  logic [25:0]        jump_target_i,
  input  logic               jr_i,
  input  logic [tamanho-1:0] jr_addr_i,
  output logic [tamanho-1:0] next_pc_c_o,
  output logic               redirect_c_o,
  output logic               fault_c_o
);

  // Pick the next PC; redirects only apply to a valid instruction in the IR.
  always_comb begin
    next_pc_c_o  = pc_i + tamanho'(4);
    redirect_c_o = 1'b0;
    if (redirect_en_i) begin
      if (jr_i) begin
        next_pc_c_o  = jr_addr_i;
        redirect_c_o = 1'b1;
      end else if (jump_i) begin
        next_pc_c_o  = tamanho'({pc_plus4_i[tamanho-1 -: 4], jump_target_i, 2'b00});
        redirect_c_o = 1'b1;
      end else if (branch_taken_i) begin
        next_pc_c_o  = pc_plus4_i + (branch_offset_i << 2);
        redirect_c_o = 1'b1;
      end
    end
  end

  // Misaligned or beyond the instruction memory; wrap-around also ends up here.
  assign fault_c_o = (next_pc_c_o[1:0] != 2'b00) ||
                     (next_pc_c_o[tamanho-1:enderecamento+2] != '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, instruction register and IDLE/RUN/HALTED control.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned        tamanho       = TAMANHO,
  parameter int unsigned        enderecamento = ENDERECAMENTO,
  parameter logic [tamanho-1:0] RESET_PC      = tamanho'(DEF_RESET_PC),
  parameter logic [tamanho-1:0] HALT_WORD     = tamanho'(DEF_HALT_WORD)
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  logic [1:0]         state_q, state_d;
  logic [tamanho-1:0] pc_q, pc_d;
  logic [tamanho-1:0] instr_q, instr_d;
  logic [tamanho-1:0] pc_out_q, pc_out_d;
  logic [tamanho-1:0] pc_plus4_q, pc_plus4_d;
  logic               valid_q, valid_d;
  logic               halt_q, halt_d;
  logic               fault_q, fault_d;

  logic [tamanho-1:0] next_pc_c;
  logic               redirect_c;
  logic               fault_c;

  fetch_unit_next_pc_sel #(
    .tamanho       (tamanho),
    .enderecamento (enderecamento)
  ) u_next_pc_sel (
    .pc_i            (pc_q),
    .pc_plus4_i      (pc_plus4_q),
    .redirect_en_i   (valid_q),
    .branch_taken_i  (bus.branch_taken),
    .branch_offset_i (bus.branch_offset),
    .jump_i          (bus.jump),
    .jump_target_i   (bus.jump_target),
    .jr_i            (bus.jr),
    .jr_addr_i       (bus.jr_addr),
    .next_pc_c_o     (next_pc_c),
    .redirect_c_o    (redirect_c),
    .fault_c_o       (fault_c)
  );

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      pc_out_q   <= '0;
      pc_plus4_q <= tamanho'(4);
      valid_q    <= 1'b0;
      halt_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
      halt_q     <= halt_d;
      fault_q    <= fault_d;
    end
  end

  // Next-state logic: halt word and faults stop fetch, redirects squash one slot.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_out_d   = pc_out_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    halt_d     = halt_q;
    fault_d    = fault_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_RUN;
        valid_d = 1'b0;
      end
      ST_RUN: begin
        if (!bus.stall) begin
          if (valid_q && (instr_q == HALT_WORD)) begin
            state_d = ST_HALTED;
            halt_d  = 1'b1;
            valid_d = 1'b0;
          end else if (fault_c) begin
            state_d = ST_HALTED;
            halt_d  = 1'b1;
            fault_d = 1'b1;
            valid_d = 1'b0;
          end else if (redirect_c) begin
            pc_d    = next_pc_c;
            instr_d = '0;
            valid_d = 1'b0;
          end else begin
            pc_d       = next_pc_c;
            instr_d    = bus.i_out;
            pc_out_d   = pc_q;
            pc_plus4_d = pc_q + tamanho'(4);
            valid_d    = 1'b1;
          end
        end
      end
      ST_HALTED: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.Address     = pc_q;
  assign bus.instr       = instr_q;
  assign bus.pc_out      = pc_out_q;
  assign bus.pc_plus4    = pc_plus4_q;
  assign bus.instr_valid = valid_q;
  assign bus.halt        = halt_q;
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit against a combinational 1024-word instruction memory.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem [0:1023];
  int          vectors;
  int          miscompares;

  fetch_unit_if #(.tamanho(32)) bus ();

  fetch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.i_out = mem[bus.Address[11:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_offset = 32'h0;
    bus.jump          = 1'b0;
    bus.jump_target   = 26'h0;
    bus.jr            = 1'b0;
    bus.jr_addr       = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_ctl();
    step();
    vectors++;
    if ({bus.Address, bus.instr, bus.pc_out, bus.instr_valid, bus.halt, bus.fault} !== {32'h0, 32'h0, 32'h0, 3'b000}) begin
      miscompares++;
      $display("FAIL reset_state: got %h want %h", {bus.Address, bus.instr, bus.pc_out, bus.instr_valid, bus.halt, bus.fault}, {32'h0, 32'h0, 32'h0, 3'b000});
    end
  endtask

  task automatic test_sequential();
    rst_n = 1'b1;
    step();
    vectors++;
    if ({bus.instr_valid, bus.Address} !== {1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL seq_idle: got %h want %h", {bus.instr_valid, bus.Address}, {1'b0, 32'h0});
    end
    step();
    vectors++;
    if ({bus.instr, bus.pc_out, bus.instr_valid, bus.Address} !== {32'h11, 32'h0, 1'b1, 32'h4}) begin
      miscompares++;
      $display("FAIL seq_word0: got %h want %h", {bus.instr, bus.pc_out, bus.instr_valid, bus.Address}, {32'h11, 32'h0, 1'b1, 32'h4});
    end
    step();
    vectors++;
    if ({bus.instr, bus.pc_out, bus.instr_valid} !== {32'h22, 32'h4, 1'b1}) begin
      miscompares++;
      $display("FAIL seq_word1: got %h want %h", {bus.instr, bus.pc_out, bus.instr_valid}, {32'h22, 32'h4, 1'b1});
    end
    step();
    vectors++;
    if ({bus.instr, bus.pc_out, bus.pc_plus4, bus.Address} !== {32'h33, 32'h8, 32'hC, 32'hC}) begin
      miscompares++;
      $display("FAIL seq_word2: got %h want %h", {bus.instr, bus.pc_out, bus.pc_plus4, bus.Address}, {32'h33, 32'h8, 32'hC, 32'hC});
    end
  endtask

  task automatic test_branch();
    bus.branch_taken  = 1'b1;
    bus.branch_offset = 32'd3;
    step();
    clear_ctl();
    vectors++;
    if ({bus.Address, bus.instr_valid, bus.instr} !== {32'h18, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL branch_bubble: got %h want %h", {bus.Address, bus.instr_valid, bus.instr}, {32'h18, 1'b0, 32'h0});
    end
    step();
    vectors++;
    if ({bus.instr, bus.pc_out, bus.instr_valid, bus.Address} !== {32'hA000_0006, 32'h18, 1'b1, 32'h1C}) begin
      miscompares++;
      $display("FAIL branch_target: got %h want %h", {bus.instr, bus.pc_out, bus.instr_valid, bus.Address}, {32'hA000_0006, 32'h18, 1'b1, 32'h1C});
    end
  endtask

  task automatic test_stall();
    bus.stall         = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_offset = 32'd5;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({bus.Address, bus.instr, bus.pc_out, bus.instr_valid} !== {32'h1C, 32'hA000_0006, 32'h18, 1'b1}) begin
        miscompares++;
        $display("FAIL stall_hold%0d: got %h want %h", i, {bus.Address, bus.instr, bus.pc_out, bus.instr_valid}, {32'h1C, 32'hA000_0006, 32'h18, 1'b1});
      end
    end
    clear_ctl();
    step();
    vectors++;
    if ({bus.instr, bus.pc_out, bus.instr_valid, bus.Address} !== {32'hA000_0007, 32'h1C, 1'b1, 32'h20}) begin
      miscompares++;
      $display("FAIL stall_resume: got %h want %h", {bus.instr, bus.pc_out, bus.instr_valid, bus.Address}, {32'hA000_0007, 32'h1C, 1'b1, 32'h20});
    end
  endtask

  task automatic test_jr_priority_fault();
    bus.jr          = 1'b1;
    bus.jr_addr     = 32'h40;
    bus.jump        = 1'b1;
    bus.jump_target = 26'h3;
    step();
    clear_ctl();
    vectors++;
    if ({bus.Address, bus.instr_valid} !== {32'h40, 1'b0}) begin
      miscompares++;
      $display("FAIL jr_priority: got %h want %h", {bus.Address, bus.instr_valid}, {32'h40, 1'b0});
    end
    step();
    vectors++;
    if ({bus.instr, bus.pc_out, bus.Address} !== {32'hA000_0010, 32'h40, 32'h44}) begin
      miscompares++;
      $display("FAIL jr_target: got %h want %h", {bus.instr, bus.pc_out, bus.Address}, {32'hA000_0010, 32'h40, 32'h44});
    end
    bus.jr      = 1'b1;
    bus.jr_addr = 32'h42;
    step();
    clear_ctl();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({bus.fault, bus.halt, bus.instr_valid, bus.Address} !== {3'b110, 32'h44}) begin
        miscompares++;
        $display("FAIL jr_misalign%0d: got %h want %h", i, {bus.fault, bus.halt, bus.instr_valid, bus.Address}, {3'b110, 32'h44});
      end
      step();
    end
  endtask

  task automatic test_halt_word();
    rst_n = 1'b0;
    step();
    mem[3] = 32'hFFFF_FFFF;
    rst_n  = 1'b1;
    for (int i = 0; i < 5; i++) step();
    vectors++;
    if ({bus.instr, bus.pc_out, bus.instr_valid, bus.halt} !== {32'hFFFF_FFFF, 32'hC, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL halt_word_loaded: got %h want %h", {bus.instr, bus.pc_out, bus.instr_valid, bus.halt}, {32'hFFFF_FFFF, 32'hC, 1'b1, 1'b0});
    end
    for (int i = 0; i < 10; i++) begin
      step();
      vectors++;
      if ({bus.halt, bus.fault, bus.instr_valid, bus.Address, bus.instr} !== {3'b100, 32'h10, 32'hFFFF_FFFF}) begin
        miscompares++;
        $display("FAIL halt_frozen%0d: got %h want %h", i, {bus.halt, bus.fault, bus.instr_valid, bus.Address, bus.instr}, {3'b100, 32'h10, 32'hFFFF_FFFF});
      end
    end
    mem[3] = 32'hA000_0003;
  endtask

  task automatic test_reset_mid_run();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.Address, bus.instr, bus.pc_out, bus.instr_valid, bus.halt, bus.fault} !== {32'h0, 32'h0, 32'h0, 3'b000}) begin
      miscompares++;
      $display("FAIL async_reset: got %h want %h", {bus.Address, bus.instr, bus.pc_out, bus.instr_valid, bus.halt, bus.fault}, {32'h0, 32'h0, 32'h0, 3'b000});
    end
    step();
    rst_n = 1'b1;
    step();
    step();
    vectors++;
    if ({bus.instr, bus.pc_out, bus.instr_valid} !== {32'h11, 32'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL restart: got %h want %h", {bus.instr, bus.pc_out, bus.instr_valid}, {32'h11, 32'h0, 1'b1});
    end
  endtask

  task automatic test_jump_branch_back_top_fault();
    bus.jump        = 1'b1;
    bus.jump_target = 26'h20;
    step();
    clear_ctl();
    vectors++;
    if ({bus.Address, bus.instr_valid} !== {32'h80, 1'b0}) begin
      miscompares++;
      $display("FAIL jump_bubble: got %h want %h", {bus.Address, bus.instr_valid}, {32'h80, 1'b0});
    end
    step();
    vectors++;
    if ({bus.instr, bus.pc_out, bus.pc_plus4} !== {32'hA000_0020, 32'h80, 32'h84}) begin
      miscompares++;
      $display("FAIL jump_target: got %h want %h", {bus.instr, bus.pc_out, bus.pc_plus4}, {32'hA000_0020, 32'h80, 32'h84});
    end
    bus.branch_taken  = 1'b1;
    bus.branch_offset = 32'hFFFF_FFFF;
    step();
    clear_ctl();
    step();
    vectors++;
    if ({bus.instr, bus.pc_out, bus.instr_valid} !== {32'hA000_0020, 32'h80, 1'b1}) begin
      miscompares++;
      $display("FAIL branch_negative: got %h want %h", {bus.instr, bus.pc_out, bus.instr_valid}, {32'hA000_0020, 32'h80, 1'b1});
    end
    bus.jr      = 1'b1;
    bus.jr_addr = 32'hFFC;
    step();
    clear_ctl();
    vectors++;
    if ({bus.Address, bus.fault} !== {32'hFFC, 1'b0}) begin
      miscompares++;
      $display("FAIL jr_last_word: got %h want %h", {bus.Address, bus.fault}, {32'hFFC, 1'b0});
    end
    step();
    vectors++;
    if ({bus.fault, bus.halt, bus.instr_valid, bus.Address} !== {3'b110, 32'hFFC}) begin
      miscompares++;
      $display("FAIL seq_out_of_range: got %h want %h", {bus.fault, bus.halt, bus.instr_valid, bus.Address}, {3'b110, 32'hFFC});
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[0] = 32'h11;
    mem[1] = 32'h22;
    mem[2] = 32'h33;
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_jr_priority_fault();
    test_halt_word();
    test_reset_mid_run();
    test_jump_branch_back_top_fault();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
